mem_access_ctrl: RTL

Sequencer and arbiter for the shared single-port memory and the MDR in the 16-bit accumulator processor. It accepts read/write requests from two requesters, instruction fetch and data (load/store), and grants them round-robin. It drives the memory address, write enable and write data. For reads, it captures returned data into the MDR through the MDR's write-enable/data inputs.

---
 rtl/mem_ctrl_pkg.sv | 21 ++
 rtl/rr_arbiter2.sv | 36 +++
 rtl/mem_access_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types for the memory access sequencer: FSM states, grant source codes, latency limits.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  localparam logic SRC_FETCH = 1'b0;
  localparam logic SRC_DATA  = 1'b1;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 4;
  localparam int CNT_W       = 2;

  function automatic bit mem_lat_legal(input int lat);
    return (lat >= MEM_LAT_MIN) && (lat <= MEM_LAT_MAX);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-source round-robin arbiter; combinational one-hot grant (bit0 fetch, bit1 data),
// gated by i_grant_en. A tie goes to the source not granted last.
module rr_arbiter2
  import mem_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic       i_grant_en,
  output logic [1:0] o_grant
);

  logic r_last_grant;

  always_comb begin
    o_grant = 2'b00;
    if (i_grant_en) begin
      case (i_req)
        2'b01:   o_grant = 2'b01;
        2'b10:   o_grant = 2'b10;
        2'b11:   o_grant = (r_last_grant == SRC_DATA) ? 2'b01 : 2'b10;
        default: o_grant = 2'b00;
      endcase
    end
  end

  // Reset to data so that fetch wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= SRC_DATA;
    end else if (|o_grant) begin
      r_last_grant <= o_grant[1];
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Arbitrates fetch/data requests onto the single-port memory and loads the MDR on reads.
// Write done at k+1, read done/MDR load at k+1+MEM_LAT; requests wait (held high) while busy.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_done,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mdr_write,
  output logic [DATA_W-1:0] mdr_in,
  output logic              busy
);

  if (!mem_lat_legal(MEM_LAT)) begin : g_bad_lat
    $error("mem_access_ctrl: MEM_LAT must be within 1..4");
  end

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_src;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [1:0]        w_grant;
  logic              w_grant_en;

  assign w_grant_en = (r_state == IDLE);

  rr_arbiter2 u_arb (
    .clk        (clk),
    .reset      (reset),
    .i_req      ({data_req, fetch_req}),
    .i_grant_en (w_grant_en),
    .o_grant    (w_grant)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // All handshake outputs decode registered state only; req inputs never reach them.
  always_comb begin
    w_next     = r_state;
    mem_we     = 1'b0;
    mdr_write  = 1'b0;
    mdr_in     = '0;
    fetch_done = 1'b0;
    data_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (|w_grant) w_next = ACCESS;
      end
      ACCESS: begin
        if (r_we) begin
          mem_we    = 1'b1;
          data_done = 1'b1;
          w_next    = IDLE;
        end else if (r_cnt == '0) begin
          w_next = CAPTURE;
        end
      end
      CAPTURE: begin
        mdr_write = 1'b1;
        mdr_in    = mem_rdata;
        if (r_src == SRC_FETCH) fetch_done = 1'b1;
        else                    data_done  = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign busy      = (r_state != IDLE);
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  // Winner's request is frozen here; later req/addr changes are ignored until IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_src   <= SRC_DATA;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (|w_grant) begin
      r_cnt  <= LAT_LOAD;
      r_src  <= w_grant[1];
      r_we   <= w_grant[1] & data_we;
      r_addr <= w_grant[1] ? data_addr : fetch_addr;
      if (w_grant[1]) r_wdata <= data_wdata;
    end else if (r_state == ACCESS && r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule
